// File: rtl/soin_mem_pkg.sv
// Shared types and constants for the unified memory port masters.
package soin_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } mem_owner_t;

  // Wide enough for any practical data width; users slice the low DATA_W/8 bits.
  localparam logic [127:0] BE_ALL = '1;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Down-counter watchdog for a bus master. A clear reloads LIMIT-1. While enabled
// it counts down to zero; o_expire is high for the enabled cycle spent at zero,
// which is the LIMIT-th cycle after the clear.
module bus_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  // Reload on clear, otherwise count down and hold at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= LOAD;
    end else if (i_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_expire = i_en & (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and the data path.
// One transaction outstanding; data wins unless IF has watched MAX_D_STREAK
// consecutive data grants. A watchdog aborts stuck transactions.
module mem_port_arbiter
  import soin_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_read,
  input  logic                i_d_write,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_be,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_mem_err,
  output logic                o_bus_err,
  output logic                o_busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  mem_state_t    state, state_nx;
  mem_owner_t    owner;
  logic [SW-1:0] streak;

  logic d_req, if_pend, d_pend;
  logic acc_rvalid, timeout, done, pick_d, arb_go;
  logic tmr_clr, tmr_en, tmr_expire;

  // Next state, arbitration decision and completion detection.
  // In ADDR the owner's own request is the one being served, so it is masked
  // from re-arbitration; a request still high after RESP counts as new.
  always_comb begin
    d_req      = i_d_read | i_d_write;
    if_pend    = i_if_req & ~((state == ADDR) & (owner == OWN_IF));
    d_pend     = d_req    & ~((state == ADDR) & (owner == OWN_D));
    acc_rvalid = i_mem_rvalid & ((state == RESP) | ((state == ADDR) & i_mem_gnt));
    timeout    = tmr_expire & ~((state == ADDR) & i_mem_gnt)
                            & ~((state == RESP) & i_mem_rvalid);
    done       = acc_rvalid | timeout;
    pick_d     = d_pend & ~(if_pend & (streak == STREAK_MAX));
    arb_go     = 1'b0;
    state_nx   = state;
    case (state)
      IDLE: begin
        if (if_pend | d_pend) begin
          arb_go   = 1'b1;
          state_nx = ADDR;
        end
      end
      ADDR, RESP: begin
        if (done) begin
          if (if_pend | d_pend) begin
            arb_go   = 1'b1;
            state_nx = ADDR;
          end else begin
            state_nx = IDLE;
          end
        end else if ((state == ADDR) && i_mem_gnt) begin
          state_nx = RESP;
        end
      end
      default: state_nx = IDLE;
    endcase
    tmr_clr = arb_go | ((state == ADDR) & i_mem_gnt & ~done);
    tmr_en  = (state != IDLE);
  end

  bus_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (tmr_clr),
    .i_en    (tmr_en),
    .o_expire(tmr_expire)
  );

  // State, owner and anti-starvation streak.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      owner  <= OWN_IF;
      streak <= '0;
    end else begin
      state <= state_nx;
      if (arb_go) begin
        owner <= pick_d ? OWN_D : OWN_IF;
        if (pick_d && if_pend) begin
          streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
        end else begin
          streak <= '0;
        end
      end else if (!i_if_req) begin
        streak <= '0;
      end
    end
  end

  // Registered bus request, payload and error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= '0;
      o_bus_err   <= 1'b0;
    end else begin
      o_mem_req <= (state_nx == ADDR);
      o_bus_err <= timeout | (acc_rvalid & i_mem_err);
      if (arb_go) begin
        if (pick_d) begin
          o_mem_we    <= i_d_write;
          o_mem_addr  <= i_d_addr;
          o_mem_wdata <= i_d_write ? i_d_wdata : '0;
          o_mem_be    <= i_d_write ? i_d_be : BE_ALL[BE_W-1:0];
        end else begin
          o_mem_we    <= 1'b0;
          o_mem_addr  <= i_if_addr;
          o_mem_wdata <= '0;
          o_mem_be    <= BE_ALL[BE_W-1:0];
        end
      end
    end
  end

  // Per-requester grant/response steering; forced zero data on timeout.
  always_comb begin
    o_busy      = (state != IDLE);
    o_if_gnt    = i_mem_gnt & (state == ADDR) & (owner == OWN_IF);
    o_d_gnt     = i_mem_gnt & (state == ADDR) & (owner == OWN_D);
    o_if_rvalid = done & (owner == OWN_IF);
    o_d_rvalid  = done & (owner == OWN_D);
    o_if_rdata  = (o_busy & ~timeout) ? i_mem_rdata : '0;
    o_d_rdata   = (o_busy & ~timeout) ? i_mem_rdata : '0;
  end

endmodule
